// File: rtl/req_enc_pkg.sv
// req_enc_pkg
//   Shared sizes and types for the 16-to-4 request encoder.
//   N_IN    number of request lines
//   IDX_W   index width
//   idx_t   line index, vec_t request/pending vector, state_t offer FSM state
package req_enc_pkg;

  localparam int N_IN  = 16;
  localparam int IDX_W = $clog2(N_IN);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [N_IN-1:0]  vec_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

endpackage

// File: rtl/prio_enc16.sv
// prio_enc16
//   Combinational 16-line priority encoder with a rotating start point.
//   The search begins at line 'base' and walks upward, wrapping past 15 to 0;
//   the first set line found wins. With base = 0 this is plain
//   lowest-index-first priority.
// Ports
//   vec   in   16  candidate lines
//   base  in   4   first line to examine
//   idx   out  4   winning line (0 when none set)
//   any   out  1   at least one line of vec is set
module prio_enc16
  import req_enc_pkg::*;
(
  input  vec_t vec,
  input  idx_t base,
  output idx_t idx,
  output logic any
);

  idx_t pos;

  always_comb begin
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int i = 0; i < N_IN; i++) begin
      // 4-bit addition wraps modulo 16 on its own
      pos = base + idx_t'(i);
      if (!any && vec[pos]) begin
        idx = pos;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_encoder16.sv
// req_encoder16
//   16-to-4 request encoder. Request strobes are merged into a pending
//   register; one line at a time is offered as a 4-bit index over a
//   valid/ready handshake, and the served line is cleared on accept.
//   Build option: REQ_ENCODER_ROUND_ROBIN_EN selects round-robin arbitration
//   (search starts one past the last granted line); otherwise the lowest
//   pending index wins.
// Ports
//   clk        in   1   rising-edge clock
//   rst        in   1   asynchronous active-high reset
//   req        in   16  request strobes, sampled every clock
//   clr        in   1   synchronous clear of all state (overrides everything)
//   out_idx    out  4   index of the line being offered
//   out_valid  out  1   out_idx is valid
//   out_ready  in   1   consumer accepts; transfer = out_valid & out_ready
//   pending    out  16  registered pending vector, includes the offered line
//   dup_err    out  1   sticky: request seen on a line already pending
//
// state    | meaning
// ST_IDLE  | nothing pending, out_valid low, out_idx holds last grant
// ST_OFFER | out_idx offered with out_valid high, held until accepted
module req_encoder16
  import req_enc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  req,
  input  logic             clr,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_IN-1:0]  pending,
  output logic             dup_err
);

  state_t state_q, state_d;
  vec_t   pending_q;
  idx_t   idx_q, idx_d;
  logic   valid_q, valid_d;
  logic   dup_q, dup_d;

  logic   xfer;
  vec_t   acc_mask;
  vec_t   nxt;
  idx_t   pe_base;
  idx_t   pe_idx;
  logic   pe_any;

  assign xfer     = valid_q & out_ready;
  assign acc_mask = xfer ? (vec_t'(1) << idx_q) : '0;
  // Clearing the accepted bit before OR-ing req lets a same-cycle request re-arm it.
  // In ST_IDLE acc_mask is zero, so this is simply pending | req.
  assign nxt      = (pending_q & ~acc_mask) | req;
  assign dup_d    = dup_q | (|(req & pending_q & ~acc_mask));

`ifdef REQ_ENCODER_ROUND_ROBIN_EN
  idx_t rr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (clr) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= idx_q + idx_t'(1);
    end
  end

  // On a transfer the next pick must already start past the line just
  // granted, so use the value rr_ptr is about to take.
  assign pe_base = xfer ? (idx_q + idx_t'(1)) : rr_ptr;
`else
  assign pe_base = '0;
`endif

  prio_enc16 u_prio (
    .vec  (nxt),
    .base (pe_base),
    .idx  (pe_idx),
    .any  (pe_any)
  );

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pe_any) begin
          state_d = ST_OFFER;
          valid_d = 1'b1;
          idx_d   = pe_idx;
        end
      end
      ST_OFFER: begin
        if (xfer) begin
          if (pe_any) begin
            idx_d = pe_idx;
          end else begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      dup_q     <= 1'b0;
    end else if (clr) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      dup_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= nxt;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      dup_q     <= dup_d;
    end
  end

  assign out_idx   = idx_q;
  assign out_valid = valid_q;
  assign pending   = pending_q;
  assign dup_err   = dup_q;

endmodule
